// File: rtl/pwm_peripheral_if.sv
// Register-write bus from the SPI stage plus the PWM pin/status outputs.
// The master side drives writes and observes outputs; the slave side is
// the PWM peripheral itself.
interface pwm_peripheral_if;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] out;
    logic        period_start;
    logic [7:0]  duty_active;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  out,
        input  period_start,
        input  duty_active
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output out,
        output period_start,
        output duty_active
    );
endinterface

// File: rtl/pwm_peripheral.sv
// Register file plus 16-channel PWM output stage.
// A prescaler divides clk into PWM counter steps; an 8-bit counter sweeps
// one 256-step period. The duty register is copied into a shadow register
// only at the period boundary, so every period runs with one duty value.
// Each pin is off, static on, or PWM-modulated by the shared shadow duty.
module pwm_peripheral #(
    parameter int PRESCALE = 3000,
    parameter int MAX_ADDR = 4
) (
    input logic             clk,
    input logic             rst,
    pwm_peripheral_if.slave bus
);

    localparam int              PRE_W    = 16;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Full duty is treated as "always high" so 0xFF has no 1/256 low gap.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        if (duty == 8'hFF) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

    // Per-pin gating: disabled pins are low, static pins high, PWM pins follow level.
    function automatic logic [15:0] pin_gate(input logic [15:0] en_o,
                                             input logic [15:0] en_p,
                                             input logic        level);
        return en_o & (~en_p | {16{level}});
    endfunction

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    logic             tick;
    logic             wrap;
    logic             wr_hit;

    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [7:0]       duty_reg;
    logic [7:0]       duty_shadow;

    logic             pwm_raw_p0;
    logic [15:0]      out_nxt_p0;
    logic [15:0]      out_p1;
    logic             period_start_p1;

    assign tick   = (pre_cnt == PRE_LAST);
    assign wrap   = tick && (pwm_cnt == 8'hFF);
    assign wr_hit = bus.wr_valid && ({25'd0, bus.wr_addr} <= 32'(MAX_ADDR));

    // Prescaler: counts 0..PRESCALE-1 and wraps; tick marks the last cycle of a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // PWM counter: one step per tick, natural 8-bit wrap 255->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Register file: accepted writes land on the same edge; out-of-map addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out   <= '0;
            en_pwm   <= '0;
            duty_reg <= '0;
        end else if (wr_hit) begin
            case (bus.wr_addr)
                ADDR_EN_OUT_LO: en_out[7:0]  <= bus.wr_data;
                ADDR_EN_OUT_HI: en_out[15:8] <= bus.wr_data;
                ADDR_EN_PWM_LO: en_pwm[7:0]  <= bus.wr_data;
                ADDR_EN_PWM_HI: en_pwm[15:8] <= bus.wr_data;
                ADDR_DUTY:      duty_reg     <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // Shadow duty: sampled from the pre-write duty_reg only at the period boundary,
    // so a write coinciding with wrap waits for the following boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow <= '0;
        end else if (wrap) begin
            duty_shadow <= duty_reg;
        end
    end

    // ---- stage p0 -> p1: pin level computed from current counter/shadow, then registered
    assign pwm_raw_p0 = pwm_level(pwm_cnt, duty_shadow);
    assign out_nxt_p0 = pin_gate(en_out, en_pwm, pwm_raw_p0);

    // Output register: pins and the period marker. period_start is high in the
    // first cycle where pwm_cnt==0 and the new shadow duty are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1          <= '0;
            period_start_p1 <= 1'b0;
        end else begin
            out_p1          <= out_nxt_p0;
            period_start_p1 <= wrap;
        end
    end

    assign bus.out          = out_p1;
    assign bus.period_start = period_start_p1;
    assign bus.duty_active  = duty_shadow;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral (PRESCALE=2).
// The reference model derives the counter position from the absolute cycle
// count since reset release and the duty in effect from the period index.
module tb_pwm_peripheral;

    localparam int P      = 2;
    localparam int PERIOD = 256 * P;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pwm_peripheral_if bus();

    pwm_peripheral #(.PRESCALE(P), .MAX_ADDR(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] o;
        logic        ps;
        logic [7:0]  d;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t mdl_e;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    int          m_c;
    int          m_step;
    int          m_cnt;
    bit          m_wrap;
    bit          m_level;
    logic [15:0] m_en_out;
    logic [15:0] m_en_pwm;
    logic [7:0]  m_duty;
    logic [7:0]  m_shadow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the period comes from m_c (cycles since reset release).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c      = 0;
            m_en_out = '0;
            m_en_pwm = '0;
            m_duty   = '0;
            m_shadow = '0;
            sb_q.delete();
        end else begin
            m_step  = m_c / P;
            m_cnt   = m_step % 256;
            m_wrap  = ((m_c % PERIOD) == PERIOD - 1);
            m_level = (m_shadow == 8'hFF) || (m_cnt < int'(m_shadow));
            mdl_e.o  = m_en_out & (m_en_pwm & {16{m_level}} | ~m_en_pwm);
            mdl_e.ps = m_wrap;
            if (m_wrap) m_shadow = m_duty;
            if (bus.wr_valid) begin
                case (bus.wr_addr)
                    7'h00: m_en_out[7:0]  = bus.wr_data;
                    7'h01: m_en_out[15:8] = bus.wr_data;
                    7'h02: m_en_pwm[7:0]  = bus.wr_data;
                    7'h03: m_en_pwm[15:8] = bus.wr_data;
                    7'h04: m_duty         = bus.wr_data;
                    default: ;
                endcase
            end
            mdl_e.d = m_shadow;
            sb_q.push_back(mdl_e);
            m_c++;
        end
    end

    // Monitor: one expected entry per active edge, compared on the falling edge.
    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("out",          {16'd0, bus.out},          {16'd0, mon_e.o});
            check("period_start", {31'd0, bus.period_start}, {31'd0, mon_e.ps});
            check("duty_active",  {24'd0, bus.duty_active},  {24'd0, mon_e.d});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    // Advance until the next edge has period position t.
    task automatic wait_to(input int t);
        for (int i = 0; i < 2 * PERIOD + 2; i++) begin
            if ((m_c % PERIOD) == t) return;
            @(posedge clk);
            #1;
        end
        n_vec++;
        n_fail++;
        $display("FAIL wait_to: position %0d not reached, got %0d", t, m_c % PERIOD);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out"},  {16'd0, bus.out},          32'd0);
        check({tag, "_duty"}, {24'd0, bus.duty_active},  32'd0);
        check({tag, "_ps"},   {31'd0, bus.period_start}, 32'd0);
    endtask

    initial begin
        bit seen;
        int a;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset and idle: all outputs stay low.
        #2 rst = 1'b1;
        #1 reset_checks("rst_init");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(600);

        // Static mode.
        wr(7'h00, 8'hA5);
        wr(7'h01, 8'h3C);
        idle(20);

        // 50 % duty on pin 0.
        wr(7'h02, 8'h01);
        wr(7'h04, 8'h80);
        idle(2 * PERIOD + 5);

        // Duty extremes.
        wr(7'h04, 8'h00);
        idle(2 * PERIOD);
        wr(7'h04, 8'hFF);
        idle(2 * PERIOD);

        // Double buffer: 0x40 active, then 0xC0 written at count 0x20.
        wr(7'h04, 8'h40);
        wait_to(0);
        idle(1);
        wait_to(8'h20 * P);
        wr(7'h04, 8'hC0);
        idle(2 * PERIOD);

        // Out-of-map writes.
        wr(7'h05, 8'hFF);
        wr(7'h7F, 8'hFF);
        idle(10);

        // Duty write coincident with wrap.
        wr(7'h04, 8'h10);
        wait_to(PERIOD - 1);
        wr(7'h04, 8'hE0);
        idle(2 * PERIOD + 10);

        // Randomized writes, back-to-back allowed.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) begin
                a = $urandom_range(8);
                wr((a == 8) ? 7'h7F : 7'(a), 8'($urandom_range(255)));
            end else begin
                idle(1);
            end
        end

        // Reset while pin 0 is in its PWM-high phase.
        wr(7'h00, 8'hFF);
        wr(7'h01, 8'hFF);
        wr(7'h02, 8'hFF);
        wr(7'h03, 8'h00);
        wr(7'h04, 8'h80);
        seen = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
            if (bus.out[0] === 1'b1 && bus.duty_active == 8'h80) seen = 1'b1;
            else idle(1);
        end
        check("pwm_high_reached", {31'd0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1 reset_checks("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr(7'h00, 8'h01);
        wr(7'h02, 8'h01);
        wr(7'h04, 8'hC0);
        idle(3 * PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
